// File: rtl/vproc_if.sv
// vproc_if: bus bundle between the vproc command-driven bus master and
// whatever sits on either side of it (command source, bus adapter).
//   master : vproc side. Drives the word bus (Addr/DataOut/WE/RD/BE/Burst*),
//            the Update toggle, command/write-data ready, responses and
//            interrupt events.
//   slave  : adapter / command-source side, the mirror image.
interface vproc_if #(
   parameter int INT_WIDTH = 32
);
   // word bus
   logic [31:0]          Addr;
   logic [31:0]          DataOut;
   logic                 WE;
   logic [3:0]           BE;
   logic                 WRAck;
   logic [31:0]          DataIn;
   logic                 RD;
   logic                 RDAck;
   logic [11:0]          Burst;
   logic                 BurstFirst;
   logic                 BurstLast;
   // adapter side-band
   logic [INT_WIDTH-1:0] Interrupt;
   logic                 Update;
   logic                 UpdateResponse;
   logic [3:0]           Node;
   // command channel
   logic                 CmdValid;
   logic                 CmdReady;
   logic                 CmdWrite;
   logic [31:0]          CmdAddr;
   logic [31:0]          CmdData;
   logic [3:0]           CmdBE;
   logic [11:0]          CmdLen;
   // burst write data, beats 2..n
   logic                 WdValid;
   logic [31:0]          WdData;
   logic                 WdReady;
   // responses
   logic                 RspValid;
   logic                 RspWrite;
   logic                 RspLast;
   logic [3:0]           RspNode;
   logic [31:0]          RspData;
   // interrupt events
   logic                 IrqValid;
   logic [INT_WIDTH-1:0] IrqVector;

   modport master (
      output Addr, DataOut, WE, BE, RD, Burst, BurstFirst, BurstLast, Update,
             CmdReady, WdReady, RspValid, RspWrite, RspLast, RspNode, RspData,
             IrqValid, IrqVector,
      input  WRAck, DataIn, RDAck, Interrupt, UpdateResponse, Node, CmdValid,
             CmdWrite, CmdAddr, CmdData, CmdBE, CmdLen, WdValid, WdData
   );

   modport slave (
      input  Addr, DataOut, WE, BE, RD, Burst, BurstFirst, BurstLast, Update,
             CmdReady, WdReady, RspValid, RspWrite, RspLast, RspNode, RspData,
             IrqValid, IrqVector,
      output WRAck, DataIn, RDAck, Interrupt, UpdateResponse, Node, CmdValid,
             CmdWrite, CmdAddr, CmdData, CmdBE, CmdLen, WdValid, WdData
   );
endinterface

// File: rtl/vproc.sv
// vproc: cycle-level virtual-processor bus master.
// Accepts single/incrementing-burst read/write commands and plays them out
// on a request/acknowledge word bus. Every edge that changes a bus output
// toggles Update; a new command waits until the adapter echoes it back on
// UpdateResponse. Interrupt changes are reported as one-cycle events.
// Ports:
//   Clk     - sole clock, rising edge
//   nReset  - asynchronous active-low reset
//   bus     - vproc_if.master (word bus, command, write data, response,
//             interrupt and Update handshake signals)
module vproc #(
   parameter int BURST_ADDR_INCR = 4,
   parameter int INT_WIDTH       = 32
) (
   input logic      Clk,
   input logic      nReset,
   vproc_if.master  bus
);

   typedef enum logic [1:0] {IDLE, WRITE, WSTALL, READ} state_t;

   // Every field here is a bus output whose change toggles Update.
   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] dout;
      logic        we;
      logic        rd;
      logic [3:0]  be;
      logic [11:0] burst;
      logic        first;
      logic        last;
   } bus_t;

   state_t               r_state, w_state_nxt;
   bus_t                 r_bus, w_bus_nxt;
   logic [11:0]          r_rem, w_rem_nxt;   // beats left after the current one
   logic                 r_upd;
   logic                 r_rsp_vld, r_rsp_wr, r_rsp_last;
   logic [3:0]           r_rsp_node;
   logic [31:0]          r_rsp_data;
   logic [INT_WIDTH-1:0] r_irq_prev, r_irq_vec;
   logic                 r_irq_vld;

   logic w_cmd_ready, w_accept, w_ack, w_more, w_wd_ready;

   assign w_cmd_ready = (r_state == IDLE) && (r_upd == bus.UpdateResponse);
   assign w_accept    = w_cmd_ready && bus.CmdValid;
   // An ack only counts when its own request is up; cross acks are ignored.
   assign w_ack       = ((r_state == WRITE) && r_bus.we && bus.WRAck) ||
                        ((r_state == READ)  && r_bus.rd && bus.RDAck);
   assign w_more      = (r_rem != 12'd0);
   assign w_wd_ready  = ((r_state == WRITE) && r_bus.we && bus.WRAck && w_more) ||
                        (r_state == WSTALL);

   always_comb begin
      w_bus_nxt   = r_bus;
      w_state_nxt = r_state;
      w_rem_nxt   = r_rem;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_bus_nxt.addr  = bus.CmdAddr;
               w_bus_nxt.be    = bus.CmdBE;
               w_bus_nxt.burst = (bus.CmdLen > 12'd1) ? bus.CmdLen : 12'd0;
               w_bus_nxt.first = (bus.CmdLen > 12'd1);
               w_bus_nxt.last  = 1'b0;
               w_rem_nxt       = (bus.CmdLen > 12'd1) ? bus.CmdLen - 12'd1 : 12'd0;
               if (bus.CmdWrite) begin
                  w_bus_nxt.dout = bus.CmdData;
                  w_bus_nxt.we   = 1'b1;
                  w_bus_nxt.rd   = 1'b0;
                  w_state_nxt    = WRITE;
               end else begin
                  w_bus_nxt.dout = 32'd0;
                  w_bus_nxt.we   = 1'b0;
                  w_bus_nxt.rd   = 1'b1;
                  w_state_nxt    = READ;
               end
            end
         end
         WRITE, READ: begin
            if (w_ack) begin
               if (w_more) begin
                  // Advance to the next beat now; if write data is late the
                  // beat is held back in WSTALL with WE low but the address
                  // and flags already point at it.
                  w_bus_nxt.addr  = r_bus.addr + 32'(BURST_ADDR_INCR);
                  w_bus_nxt.first = 1'b0;
                  w_bus_nxt.last  = (r_rem == 12'd1);
                  w_rem_nxt       = r_rem - 12'd1;
                  if (r_state == WRITE) begin
                     if (bus.WdValid) begin
                        w_bus_nxt.dout = bus.WdData;
                     end else begin
                        w_bus_nxt.we = 1'b0;
                        w_state_nxt  = WSTALL;
                     end
                  end
               end else begin
                  w_bus_nxt.we    = 1'b0;
                  w_bus_nxt.rd    = 1'b0;
                  w_bus_nxt.burst = 12'd0;
                  w_bus_nxt.first = 1'b0;
                  w_bus_nxt.last  = 1'b0;
                  w_state_nxt     = IDLE;
               end
            end
         end
         WSTALL: begin
            if (bus.WdValid) begin
               w_bus_nxt.dout = bus.WdData;
               w_bus_nxt.we   = 1'b1;
               w_state_nxt    = WRITE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         r_state    <= IDLE;
         r_bus      <= '0;
         r_rem      <= '0;
         r_upd      <= 1'b0;
         r_rsp_vld  <= 1'b0;
         r_rsp_wr   <= 1'b0;
         r_rsp_last <= 1'b0;
         r_rsp_node <= '0;
         r_rsp_data <= '0;
         r_irq_prev <= '0;
         r_irq_vec  <= '0;
         r_irq_vld  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_bus   <= w_bus_nxt;
         r_rem   <= w_rem_nxt;
         if (w_bus_nxt != r_bus)
            r_upd <= ~r_upd;

         r_rsp_vld <= w_ack;
         if (w_ack) begin
            r_rsp_wr   <= r_bus.we;
            r_rsp_last <= !w_more;
            r_rsp_node <= bus.Node;
            r_rsp_data <= r_bus.rd ? bus.DataIn : 32'd0;
         end

         r_irq_prev <= bus.Interrupt;
         r_irq_vld  <= (bus.Interrupt != r_irq_prev);
         if (bus.Interrupt != r_irq_prev)
            r_irq_vec <= bus.Interrupt;
      end
   end

   assign bus.Addr       = r_bus.addr;
   assign bus.DataOut    = r_bus.dout;
   assign bus.WE         = r_bus.we;
   assign bus.RD         = r_bus.rd;
   assign bus.BE         = r_bus.be;
   assign bus.Burst      = r_bus.burst;
   assign bus.BurstFirst = r_bus.first;
   assign bus.BurstLast  = r_bus.last;
   assign bus.Update     = r_upd;
   assign bus.CmdReady   = w_cmd_ready;
   assign bus.WdReady    = w_wd_ready;
   assign bus.RspValid   = r_rsp_vld;
   assign bus.RspWrite   = r_rsp_wr;
   assign bus.RspLast    = r_rsp_last;
   assign bus.RspNode    = r_rsp_node;
   assign bus.RspData    = r_rsp_data;
   assign bus.IrqValid   = r_irq_vld;
   assign bus.IrqVector  = r_irq_vec;

endmodule

// File: tb/tb_vproc.sv
// tb_vproc: drives vproc with a table of directed commands, hand-written
// corner sequences (Update hold, interrupt events, reset mid-burst) and
// random commands. Expected beats are derived per command: beat k sits at
// start+4k (mod 2^32), burst flags mark beat 0 / beat n-1, and every acked
// beat yields one response one cycle later.
module tb_vproc;
   localparam int INT_W = 32;

   logic Clk    = 1'b0;
   logic nReset = 1'b0;

   vproc_if #(.INT_WIDTH(INT_W)) bus ();

   vproc #(.BURST_ADDR_INCR(4), .INT_WIDTH(INT_W)) dut (
      .Clk    (Clk),
      .nReset (nReset),
      .bus    (bus)
   );

   always #5 Clk = ~Clk;

   int checks = 0;
   int errors = 0;
   bit hold_upd = 1'b0;

   typedef struct {
      bit          wr;
      logic [31:0] a;
      logic [11:0] len;
      logic [3:0]  be;
      logic [31:0] d0;
      int          ack_wait;
      int          wd_low;
      int          exp_rsp;
      logic [31:0] exp_last;
      int          exp_req;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Clock to the next falling edge; the adapter echoes Update there.
   task automatic tick();
      @(posedge Clk);
      @(negedge Clk);
      if (!hold_upd) bus.UpdateResponse = bus.Update;
   endtask

   function automatic logic [83:0] tup();
      return {bus.Addr, bus.DataOut, bus.WE, bus.RD, bus.BE, bus.Burst,
              bus.BurstFirst, bus.BurstLast};
   endfunction

   // ack_prob < 0: each beat is acked after ack_wait low cycles.
   task automatic run_cmd(input bit wr, input logic [31:0] a, input logic [11:0] len,
                          input logic [3:0] be, input logic [31:0] d0,
                          input int ack_wait, input int ack_prob,
                          input int wd_low, input int wd_prob,
                          output int n_rsp, output logic [31:0] last_a, output int req_cyc);
      logic [31:0] wdat[$];
      logic [83:0] prev_t, cur_t;
      logic        prev_u, req, ack_now, m_ack, o_ack, wdr_exp;
      logic        pend, pend_last;
      logic [31:0] pend_data;
      int n, k, wi, cyc, waited, budget;
      n = (len > 12'd1) ? int'(len) : 1;
      for (int i = 0; i < n; i++) wdat.push_back((i == 0) ? d0 : $urandom);
      n_rsp = 0; req_cyc = 0; last_a = '0;
      k = 0; wi = 1; cyc = 0; waited = 0; budget = 0;
      pend = 1'b0; pend_last = 1'b0; pend_data = '0;
      while (!bus.CmdReady && budget < 50) begin
         tick();
         budget++;
      end
      chk("cmd_ready", 32'(bus.CmdReady), 32'd1);
      bus.CmdValid = 1'b1; bus.CmdWrite = wr; bus.CmdAddr = a; bus.CmdData = d0;
      bus.CmdBE = be; bus.CmdLen = len; bus.WdValid = 1'b0;
      bus.WRAck = 1'b0; bus.RDAck = 1'b0;
      prev_t = tup(); prev_u = bus.Update;
      tick();
      bus.CmdValid = 1'b0;
      while (n_rsp < n && cyc < 300) begin
         cur_t = tup();
         chk("update_toggle", 32'(bus.Update ^ prev_u), 32'(cur_t != prev_t));
         prev_t = cur_t; prev_u = bus.Update;
         if (pend) begin
            chk("rsp_valid", 32'(bus.RspValid), 32'd1);
            chk("rsp_write", 32'(bus.RspWrite), 32'(wr));
            chk("rsp_last",  32'(bus.RspLast), 32'(pend_last));
            chk("rsp_node",  32'(bus.RspNode), 32'(bus.Node));
            chk("rsp_data",  bus.RspData, wr ? 32'd0 : pend_data);
            n_rsp++;
            pend = 1'b0;
         end else begin
            chk("rsp_idle", 32'(bus.RspValid), 32'd0);
         end
         req = wr ? bus.WE : bus.RD;
         chk("req_other", 32'(wr ? bus.RD : bus.WE), 32'd0);
         ack_now = 1'b0;
         if (req) begin
            if (k >= n) begin
               chk("extra_beat", 32'(k), 32'(n - 1));
               break;
            end
            req_cyc++;
            chk("addr",   bus.Addr, a + 32'(4 * k));
            chk("be",     32'(bus.BE), 32'(be));
            chk("burst",  32'(bus.Burst), (n > 1) ? 32'(len) : 32'd0);
            chk("bfirst", 32'(bus.BurstFirst), 32'(n > 1 && k == 0));
            chk("blast",  32'(bus.BurstLast), 32'(n > 1 && k == n - 1));
            chk("dout",   bus.DataOut, wr ? wdat[k] : 32'd0);
            ack_now = (ack_prob < 0) ? (waited >= ack_wait)
                                     : ($urandom_range(0, 99) < ack_prob);
         end
         wdr_exp = wr && (n > 1) && ((req && ack_now && k < n - 1) || (!req && k > 0 && k < n));
         m_ack = req ? ack_now : 1'($urandom_range(0, 1));
         o_ack = 1'($urandom_range(0, 1));
         bus.WRAck   = wr ? m_ack : o_ack;
         bus.RDAck   = wr ? o_ack : m_ack;
         bus.DataIn  = wr ? $urandom : d0 + 32'(k);
         bus.WdData  = (wi < n) ? wdat[wi] : $urandom;
         bus.WdValid = (cyc < wd_low) ? 1'b0 : ($urandom_range(0, 99) < wd_prob);
         #1;
         chk("wd_ready", 32'(bus.WdReady), 32'(wdr_exp));
         if (wdr_exp && bus.WdValid) wi++;
         if (ack_now) begin
            last_a = bus.Addr;
            pend = 1'b1; pend_last = (k == n - 1); pend_data = d0 + 32'(k);
            k++;
            waited = 0;
         end else if (req) begin
            waited++;
         end
         cyc++;
         tick();
      end
      chk("rsp_count", 32'(n_rsp), 32'(n));
      chk("req_drop", 32'(bus.WE | bus.RD), 32'd0);
      bus.WRAck = 1'b0; bus.RDAck = 1'b0; bus.WdValid = 1'b0;
   endtask

   initial begin
      vec_t        tbl[5];
      int          nr, rc;
      logic [31:0] la, v, prev_irq;
      logic [11:0] rl;

      bus.WRAck = 0; bus.RDAck = 0; bus.DataIn = 0; bus.Interrupt = 0;
      bus.UpdateResponse = 0; bus.Node = 4'hA; bus.CmdValid = 0; bus.CmdWrite = 0;
      bus.CmdAddr = 0; bus.CmdData = 0; bus.CmdBE = 0; bus.CmdLen = 0;
      bus.WdValid = 0; bus.WdData = 0;

      // reset state
      #1;
      chk("rst_outs", 32'({bus.WE, bus.RD, bus.Update, bus.RspValid, bus.IrqValid,
                           bus.BurstFirst, bus.BurstLast}), 32'd0);
      chk("rst_addr", bus.Addr, 32'd0);
      chk("rst_burst", 32'(bus.Burst), 32'd0);
      @(negedge Clk);
      nReset = 1'b1;
      tick();

      //            wr  addr           len  be    d0            wait low rsp last          req
      tbl[0] = '{1'b1, 32'h0000_0100, 12'd1, 4'hF, 32'hDEADBEEF, 3, 0, 1, 32'h0000_0100, 4};
      tbl[1] = '{1'b0, 32'h0000_0200, 12'd0, 4'hF, 32'h12345678, 1, 0, 1, 32'h0000_0200, 2};
      tbl[2] = '{1'b1, 32'h0000_1000, 12'd4, 4'hF, 32'h11110000, 0, 0, 4, 32'h0000_100C, 4};
      tbl[3] = '{1'b1, 32'h0000_2000, 12'd4, 4'h3, 32'h22220000, 0, 2, 4, 32'h0000_200C, 4};
      tbl[4] = '{1'b0, 32'hFFFF_FFFC, 12'd3, 4'hF, 32'h33330000, 0, 0, 3, 32'h0000_0004, 3};
      for (int i = 0; i < 5; i++) begin
         run_cmd(tbl[i].wr, tbl[i].a, tbl[i].len, tbl[i].be, tbl[i].d0,
                 tbl[i].ack_wait, -1, tbl[i].wd_low, 100, nr, la, rc);
         chk("tbl_rsp", 32'(nr), 32'(tbl[i].exp_rsp));
         chk("tbl_last_addr", la, tbl[i].exp_last);
         chk("tbl_req_cycles", 32'(rc), 32'(tbl[i].exp_req));
      end

      // Update not echoed: no command may be taken
      tick();
      hold_upd = 1'b1;
      bus.UpdateResponse = ~bus.Update;
      bus.CmdValid = 1'b1; bus.CmdWrite = 1'b1; bus.CmdAddr = 32'h40; bus.CmdLen = 12'd1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("hold_cmd_ready", 32'(bus.CmdReady), 32'd0);
         chk("hold_no_req", 32'(bus.WE | bus.RD), 32'd0);
      end
      bus.CmdValid = 1'b0;
      hold_upd = 1'b0;
      bus.UpdateResponse = bus.Update;
      tick();

      // interrupt events: first 0 -> 5, then a mix of repeats and changes
      prev_irq = 32'd0;
      for (int i = 0; i < 10; i++) begin
         v = (i == 0) ? 32'h5 : ((i % 3 == 0) ? prev_irq : $urandom);
         bus.Interrupt = v;
         tick();
         chk("irq_valid", 32'(bus.IrqValid), 32'(v != prev_irq));
         if (v != prev_irq) chk("irq_vector", bus.IrqVector, v);
         prev_irq = v;
      end
      tick();
      chk("irq_quiet", 32'(bus.IrqValid), 32'd0);

      // random commands
      for (int i = 0; i < 40; i++) begin
         bus.Node = 4'($urandom);
         rl = 12'($urandom_range(0, 6));
         run_cmd(1'($urandom_range(0, 1)),
                 (i % 5 == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC),
                 rl, 4'($urandom), $urandom, 0, 60, 0, 60, nr, la, rc);
      end

      // reset in the middle of a write burst
      bus.Node = 4'h3;
      bus.CmdValid = 1'b1; bus.CmdWrite = 1'b1; bus.CmdAddr = 32'h3000;
      bus.CmdData = 32'hCAFE0000; bus.CmdBE = 4'hF; bus.CmdLen = 12'd8;
      bus.WRAck = 1'b1; bus.WdValid = 1'b1; bus.WdData = 32'hCAFE0001;
      tick();
      bus.CmdValid = 1'b0;
      tick();
      tick();
      chk("mid_burst_we", 32'(bus.WE), 32'd1);
      #2 nReset = 1'b0;
      #1;
      chk("async_rst_ctl", 32'({bus.WE, bus.RD, bus.Update, bus.RspValid, bus.IrqValid,
                                bus.BurstFirst, bus.BurstLast}), 32'd0);
      chk("async_rst_addr", bus.Addr, 32'd0);
      chk("async_rst_dout", bus.DataOut, 32'd0);
      chk("async_rst_burst", 32'({bus.Burst, bus.BE}), 32'd0);
      tick();
      nReset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("post_rst_rsp", 32'(bus.RspValid), 32'd0);
         chk("post_rst_we", 32'(bus.WE), 32'd0);
      end
      bus.WRAck = 1'b0; bus.WdValid = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end
endmodule
